d16_mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one 32-bit synchronous word memory between the d16 core's instruction-fetch port and its 16-bit data port. It sits between `d16_top` and the memory array. It serialises fetch and load/store requests, performs halfword steering for data accesses, and returns a one-cycle acknowledge pulse that the core uses as its stall release.

---
 rtl/d16_mem_arbiter_pkg.sv | 19 +
 rtl/d16_arb_pick.sv | 32 +++
 rtl/d16_mem_arbiter.sv | 117 +++++++++++
 tb/tb_d16_mem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d16_mem_arbiter_pkg.sv
// d16 memory arbiter shared types.
// State and grant encodings used by the arbiter and its grant chooser.
package d16_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    D16_ARB_IDLE  = 2'd0,
    D16_ARB_ISSUE = 2'd1,
    D16_ARB_WAIT  = 2'd2,
    D16_ARB_DONE  = 2'd3
  } arb_state_t;

  localparam logic D16_ARB_GNT_INS  = 1'b0;
  localparam logic D16_ARB_GNT_DATA = 1'b1;

  function automatic logic [1:0] hw_we(input logic hsel);
    return hsel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/d16_arb_pick.sv
// d16 arbiter grant chooser.
// Combinational pick between fetch and data requests.
module d16_arb_pick
  import d16_mem_arbiter_pkg::*;
#(
  parameter int DATA_PRIO = 0
) (
  input  logic ins_req,
  input  logic data_req,
  input  logic last_grant,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = ins_req | data_req;
    gnt   = D16_ARB_GNT_INS;
    if (ins_req && data_req) begin
      // on conflict, round-robin favours whoever was not served last
      if (DATA_PRIO != 0) begin
        gnt = D16_ARB_GNT_DATA;
      end else if (last_grant == D16_ARB_GNT_INS) begin
        gnt = D16_ARB_GNT_DATA;
      end else begin
        gnt = D16_ARB_GNT_INS;
      end
    end else if (data_req) begin
      gnt = D16_ARB_GNT_DATA;
    end
  end

endmodule

// File: rtl/d16_mem_arbiter.sv
// d16 single-port memory arbiter.
// Serialises fetch and halfword data accesses onto one word memory.
module d16_mem_arbiter
  import d16_mem_arbiter_pkg::*;
#(
  parameter int DATA_PRIO = 0,
  parameter int MEM_AW    = 14
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ins_req,
  input  logic [15:0]       ins_a,
  output logic [31:0]       ins_di,
  output logic              ins_ack,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [15:0]       data_a,
  input  logic [15:0]       data_do,
  output logic [15:0]       data_di,
  output logic              data_ack,
  output logic [MEM_AW-1:0] mem_a,
  output logic              mem_re,
  output logic [1:0]        mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  arb_state_t        state;
  arb_state_t        state_nx;
  logic              gnt_q;
  logic              last_grant;
  logic              we_q;
  logic              hsel_q;
  logic [MEM_AW-1:0] a_q;
  logic              pick_gnt;
  logic              pick_valid;
  logic [15:0]       win_a;
  logic              take;
  logic              unused_abits;

  d16_arb_pick #(
    .DATA_PRIO(DATA_PRIO)
  ) u_pick (
    .ins_req   (ins_req),
    .data_req  (data_req),
    .last_grant(last_grant),
    .gnt       (pick_gnt),
    .valid     (pick_valid)
  );

  assign win_a = (pick_gnt == D16_ARB_GNT_DATA) ? data_a : ins_a;
  assign take  = (state == D16_ARB_IDLE) && pick_valid;
  assign unused_abits = ^win_a[1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= D16_ARB_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      D16_ARB_IDLE:  if (pick_valid) state_nx = D16_ARB_ISSUE;
      D16_ARB_ISSUE: state_nx = we_q ? D16_ARB_DONE : D16_ARB_WAIT;
      D16_ARB_WAIT:  state_nx = D16_ARB_DONE;
      D16_ARB_DONE:  state_nx = D16_ARB_IDLE;
      default:       state_nx = D16_ARB_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gnt_q      <= D16_ARB_GNT_INS;
      last_grant <= D16_ARB_GNT_INS;
      we_q       <= 1'b0;
      hsel_q     <= 1'b0;
      a_q        <= '0;
      mem_wd     <= '0;
      ins_di     <= '0;
      data_di    <= '0;
    end else begin
      if (take) begin
        gnt_q      <= pick_gnt;
        last_grant <= pick_gnt;
        we_q       <= (pick_gnt == D16_ARB_GNT_DATA) && data_we;
        hsel_q     <= data_a[1];
        a_q        <= win_a[MEM_AW+1:2];
        if ((pick_gnt == D16_ARB_GNT_DATA) && data_we) begin
          mem_wd <= {data_do, data_do};
        end
      end
      if (state == D16_ARB_WAIT) begin
        if (gnt_q == D16_ARB_GNT_INS) begin
          ins_di <= mem_rd;
        end else begin
          data_di <= hsel_q ? mem_rd[31:16] : mem_rd[15:0];
        end
      end
    end
  end

  // a store caught by reset in ISSUE must never reach the array
  always_comb begin
    mem_a    = a_q;
    mem_re   = (state == D16_ARB_ISSUE) && !we_q;
    mem_we   = 2'b00;
    if ((state == D16_ARB_ISSUE) && we_q && !sys_rst) begin
      mem_we = hw_we(hsel_q);
    end
    ins_ack  = (state == D16_ARB_DONE) && (gnt_q == D16_ARB_GNT_INS);
    data_ack = (state == D16_ARB_DONE) && (gnt_q == D16_ARB_GNT_DATA);
  end

endmodule

// File: tb/tb_d16_mem_arbiter.sv
// Bench for d16_mem_arbiter: round-robin and data-priority instances
// side by side, each against a transaction-level model and a word RAM.
module tb_d16_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
  } req_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        ram_load;
  logic        ins_req  [2];
  logic [15:0] ins_a    [2];
  logic [31:0] ins_di   [2];
  logic        ins_ack  [2];
  logic        data_req [2];
  logic        data_we  [2];
  logic [15:0] data_a   [2];
  logic [15:0] data_do  [2];
  logic [15:0] data_di  [2];
  logic        data_ack [2];
  logic [13:0] mem_a    [2];
  logic        mem_re   [2];
  logic [1:0]  mem_we   [2];
  logic [31:0] mem_wd   [2];
  logic [31:0] mem_rd   [2];

  logic [31:0] ram  [2][16384];
  logic [31:0] rmem [2][16384];

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    d16_mem_arbiter #(
      .DATA_PRIO(g),
      .MEM_AW   (14)
    ) u_dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .ins_req (ins_req[g]),
      .ins_a   (ins_a[g]),
      .ins_di  (ins_di[g]),
      .ins_ack (ins_ack[g]),
      .data_req(data_req[g]),
      .data_we (data_we[g]),
      .data_a  (data_a[g]),
      .data_do (data_do[g]),
      .data_di (data_di[g]),
      .data_ack(data_ack[g]),
      .mem_a   (mem_a[g]),
      .mem_re  (mem_re[g]),
      .mem_we  (mem_we[g]),
      .mem_wd  (mem_wd[g]),
      .mem_rd  (mem_rd[g])
    );
  end

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] x;
    if (i == 2) return 32'hA1B2C3D4;
    x = 32'(i) * 32'h9E3779B1;
    return x ^ 32'h13572468;
  endfunction

  always @(posedge sys_clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_load) begin
        for (int i = 0; i < 16384; i++) ram[g][i] <= init_word(i);
      end else begin
        if (mem_we[g][1]) ram[g][mem_a[g]][31:16] <= mem_wd[g][31:16];
        if (mem_we[g][0]) ram[g][mem_a[g]][15:0] <= mem_wd[g][15:0];
        if (mem_re[g]) mem_rd[g] <= ram[g][mem_a[g]];
      end
    end
  end

  task automatic chk(input string name, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h at %0t",
               name, g, act, exp, $time);
    end
  endtask

  // transaction-level model: one access in flight per instance,
  // all expectations are cycle numbers relative to the grant edge
  int          e;
  int          busy [2];
  int          re_e [2];
  int          we_e [2];
  int          wr_e [2];
  int          ack_e[2];
  logic        gnt_d[2];
  logic        last_d[2];
  logic        rst_chk[2];
  logic        rd_acc[2];
  logic [13:0] xa [2];
  logic [1:0]  xwe[2];
  logic [31:0] xwd[2];
  logic [31:0] xrd[2];
  logic [13:0] wr_w[2];
  logic        wr_h[2];
  logic [15:0] wr_d[2];

  initial begin
    logic        win;
    logic [15:0] a;
    logic [31:0] w;
    e = 0;
    for (int g = 0; g < 2; g++) begin
      busy[g] = 0; re_e[g] = -1; we_e[g] = -1; wr_e[g] = -1;
      ack_e[g] = -1; gnt_d[g] = 0; last_d[g] = 0;
      rst_chk[g] = 0; rd_acc[g] = 0;
      for (int i = 0; i < 16384; i++) rmem[g][i] = init_word(i);
    end
    forever begin
      @(posedge sys_clk);
      #1;
      e++;
      for (int g = 0; g < 2; g++) begin
        if (sys_rst) begin
          busy[g] = e + 1; re_e[g] = -1; we_e[g] = -1;
          wr_e[g] = -1; ack_e[g] = -1; last_d[g] = 0;
          rst_chk[g] = 1;
        end else begin
          rst_chk[g] = 0;
          if (e == wr_e[g]) begin
            if (wr_h[g]) rmem[g][wr_w[g]][31:16] = wr_d[g];
            else rmem[g][wr_w[g]][15:0] = wr_d[g];
          end
          if (e >= busy[g] && (ins_req[g] || data_req[g])) begin
            if (ins_req[g] && data_req[g])
              win = (g == 1) ? 1'b1 : !last_d[g];
            else
              win = data_req[g];
            last_d[g] = win;
            gnt_d[g]  = win;
            a = win ? data_a[g] : ins_a[g];
            xa[g] = a[15:2];
            w = rmem[g][a[15:2]];
            if (win && data_we[g]) begin
              re_e[g] = -1; we_e[g] = e; wr_e[g] = e + 1;
              ack_e[g] = e + 1; busy[g] = e + 3; rd_acc[g] = 0;
              xwe[g] = a[1] ? 2'b10 : 2'b01;
              xwd[g] = {data_do[g], data_do[g]};
              wr_w[g] = a[15:2]; wr_h[g] = a[1]; wr_d[g] = data_do[g];
            end else begin
              re_e[g] = e; we_e[g] = -1; wr_e[g] = -1;
              ack_e[g] = e + 2; busy[g] = e + 4; rd_acc[g] = 1;
              xwe[g] = 2'b00;
              if (win) xrd[g] = a[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
              else xrd[g] = w;
            end
          end
        end
        chk("mem_re", g, 32'(mem_re[g]), 32'(e == re_e[g]));
        chk("mem_we", g, 32'(mem_we[g]),
            32'((e == we_e[g]) ? xwe[g] : 2'b00));
        if (e == re_e[g] || e == we_e[g])
          chk("mem_a", g, 32'(mem_a[g]), 32'(xa[g]));
        if (e == we_e[g]) chk("mem_wd", g, mem_wd[g], xwd[g]);
        chk("ins_ack", g, 32'(ins_ack[g]),
            32'(e == ack_e[g] && !gnt_d[g]));
        chk("data_ack", g, 32'(data_ack[g]),
            32'(e == ack_e[g] && gnt_d[g]));
        if (e == ack_e[g] && rd_acc[g]) begin
          if (gnt_d[g]) chk("data_di", g, 32'(data_di[g]), xrd[g]);
          else chk("ins_di", g, ins_di[g], xrd[g]);
        end
        if (rst_chk[g]) begin
          chk("rst_mem_a", g, 32'(mem_a[g]), 32'h0);
          chk("rst_mem_wd", g, mem_wd[g], 32'h0);
          chk("rst_ins_di", g, ins_di[g], 32'h0);
          chk("rst_data_di", g, 32'(data_di[g]), 32'h0);
        end
        chk("re_we_excl", g, 32'(mem_re[g] && (mem_we[g] != 2'b00)), 32'h0);
      end
    end
  end

  // requester side: k = 2*instance + port, port 0 fetch, port 1 data
  req_t        qs [4][$];
  bit          done [4];
  int          wcnt [4];
  int          iss_cyc [4];
  int          ack_cyc [4];
  int          cyc = 0;
  bit          gap_en;
  logic [31:0] last_idi [2];
  logic [15:0] last_ddi [2];
  logic [13:0] last_re_a [2];
  logic [13:0] last_we_a [2];
  logic [1:0]  last_we_m [2];
  logic [15:0] ack_hist [2];
  int          dack_n [2];
  int          b2b [$];

  task automatic set_req(input int g, input int p, input logic v);
    if (p == 0) ins_req[g] = v;
    else data_req[g] = v;
  endtask

  task automatic drive_port(input int g, input int p);
    int   k;
    logic ack;
    logic rq;
    req_t it;
    k   = g * 2 + p;
    ack = (p == 0) ? ins_ack[g] : data_ack[g];
    rq  = (p == 0) ? ins_req[g] : data_req[g];
    if (sys_rst) begin
      set_req(g, p, 1'b0);
      done[k] = 0;
      wcnt[k] = 0;
    end else if (ack) begin
      done[k] = 1;
      wcnt[k] = 0;
      ack_cyc[k] = cyc;
      ack_hist[g] = {ack_hist[g][14:0], 1'(p)};
      if (p == 0) last_idi[g] = ins_di[g];
      else begin
        last_ddi[g] = data_di[g];
        dack_n[g]++;
      end
      if (k == 0) b2b.push_back(cyc);
    end else if (done[k] || !rq) begin
      done[k] = 0;
      wcnt[k] = 0;
      if (qs[k].size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
        it = qs[k].pop_front();
        iss_cyc[k] = cyc;
        if (p == 0) begin
          ins_req[g] = 1'b1;
          ins_a[g]   = it.a;
        end else begin
          data_req[g] = 1'b1;
          data_we[g]  = it.we;
          data_a[g]   = it.a;
          data_do[g]  = it.d;
        end
      end else begin
        set_req(g, p, 1'b0);
      end
    end else begin
      wcnt[k]++;
      if (wcnt[k] > 400) begin
        checks++;
        failures++;
        $display("FAIL req_timeout[%0d] port=%0d no ack after %0d cycles",
                 g, p, wcnt[k]);
        set_req(g, p, 1'b0);
        wcnt[k] = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (mem_re[g]) last_re_a[g] = mem_a[g];
      if (mem_we[g] != 2'b00) begin
        last_we_a[g] = mem_a[g];
        last_we_m[g] = mem_we[g];
      end
      drive_port(g, 0);
      drive_port(g, 1);
    end
  endtask

  task automatic wait_idle(input int limit);
    bit idle;
    idle = 0;
    for (int i = 0; i < limit && !idle; i++) begin
      step();
      idle = 1;
      for (int k = 0; k < 4; k++) begin
        if (qs[k].size() != 0 || done[k]) idle = 0;
      end
      for (int g = 0; g < 2; g++) begin
        if (ins_req[g] || data_req[g]) idle = 0;
      end
    end
    if (!idle) begin
      checks++;
      failures++;
      $display("FAIL wait_idle did not drain within %0d cycles", limit);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [15:0] a,
                              input logic [15:0] d);
    req_t r;
    r.we = we;
    r.a  = a;
    r.d  = d;
    return r;
  endfunction

  initial begin
    logic [31:0] w16;
    logic [31:0] w17;
    bit          hit;
    int          dn;
    sys_rst  = 1'b1;
    ram_load = 1'b1;
    gap_en   = 0;
    for (int g = 0; g < 2; g++) begin
      ins_req[g] = 0; ins_a[g] = '0; data_req[g] = 0;
      data_we[g] = 0; data_a[g] = '0; data_do[g] = '0;
      ack_hist[g] = '0; dack_n[g] = 0;
    end
    repeat (3) step();
    sys_rst  = 1'b0;
    ram_load = 1'b0;

    // both ports contending right out of reset
    qs[0].push_back(mk(1'b0, 16'h0000, 16'h0));
    qs[0].push_back(mk(1'b0, 16'h0004, 16'h0));
    qs[1].push_back(mk(1'b0, 16'h0010, 16'h0));
    qs[1].push_back(mk(1'b0, 16'h0014, 16'h0));
    qs[2].push_back(mk(1'b0, 16'h0020, 16'h0));
    qs[3].push_back(mk(1'b0, 16'h0030, 16'h0));
    qs[3].push_back(mk(1'b0, 16'h0034, 16'h0));
    qs[3].push_back(mk(1'b0, 16'h0038, 16'h0));
    wait_idle(200);
    chk("rr_order", 0, 32'(ack_hist[0][3:0]), 32'h0000000A);
    chk("prio_order", 1, 32'(ack_hist[1][3:0]), 32'h0000000E);

    // lone fetch
    qs[0].push_back(mk(1'b0, 16'h0008, 16'h0));
    wait_idle(50);
    chk("fetch_lat", 0, 32'(ack_cyc[0] - iss_cyc[0]), 32'd3);
    chk("fetch_data", 0, last_idi[0], 32'hA1B2C3D4);
    chk("fetch_addr", 0, 32'(last_re_a[0]), 32'd2);

    // halfword store then loads of both halves
    w16 = init_word(16);
    qs[1].push_back(mk(1'b1, 16'h0042, 16'h1234));
    wait_idle(50);
    chk("st_lat", 0, 32'(ack_cyc[1] - iss_cyc[1]), 32'd2);
    chk("st_mask", 0, 32'(last_we_m[0]), 32'h2);
    chk("st_addr", 0, 32'(last_we_a[0]), 32'h10);
    chk("st_hi", 0, 32'(ram[0][16][31:16]), 32'h1234);
    chk("st_lo_kept", 0, 32'(ram[0][16][15:0]), 32'(w16[15:0]));
    qs[1].push_back(mk(1'b0, 16'h0040, 16'h0));
    wait_idle(50);
    chk("ld_lo", 0, 32'(last_ddi[0]), 32'(w16[15:0]));
    chk("ld_lat", 0, 32'(ack_cyc[1] - iss_cyc[1]), 32'd3);
    qs[1].push_back(mk(1'b0, 16'h0042, 16'h0));
    wait_idle(50);
    chk("ld_hi", 0, 32'(last_ddi[0]), 32'h1234);

    // back-to-back fetches
    b2b.delete();
    qs[0].push_back(mk(1'b0, 16'h0000, 16'h0));
    qs[0].push_back(mk(1'b0, 16'h0004, 16'h0));
    qs[0].push_back(mk(1'b0, 16'h0008, 16'h0));
    wait_idle(80);
    chk("b2b_count", 0, 32'(b2b.size()), 32'd3);
    if (b2b.size() == 3) begin
      chk("b2b_gap1", 0, 32'(b2b[1] - b2b[0]), 32'd4);
      chk("b2b_gap2", 0, 32'(b2b[2] - b2b[1]), 32'd4);
    end

    // reset landing in the ISSUE cycle of a store
    w17 = init_word(17);
    dn  = dack_n[0];
    hit = 0;
    qs[1].push_back(mk(1'b1, 16'h0044, 16'hBEEF));
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      if (mem_we[0] != 2'b00) hit = 1;
    end
    chk("rstw_issue_seen", 0, 32'(hit), 32'h1);
    sys_rst = 1'b1;
    #1;
    chk("rstw_we_gated", 0, 32'(mem_we[0]), 32'h0);
    step();
    sys_rst = 1'b0;
    repeat (6) step();
    chk("rstw_word_kept", 0, ram[0][17], w17);
    chk("rstw_no_ack", 0, 32'(dack_n[0] - dn), 32'h0);

    // randomized traffic on both instances
    gap_en = 1;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 40; n++) begin
        qs[k].push_back(mk((k % 2 == 1) ? 1'($urandom_range(1)) : 1'b0,
                           16'($urandom_range(16'hFFFF)),
                           16'($urandom)));
      end
    end
    wait_idle(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
